// File: rtl/gpio_cfg_loader.sv
// rtl/gpio_cfg_loader.sv - GPIO pad configuration word store and serial chain loader
// Optional readback checking is built when SERIAL_READBACK_EN is defined.
module gpio_cfg_loader #(
  parameter int NUM_IO = 38,
  parameter int CFG_W = 13,
  parameter int CLKDIV = 4,
  parameter logic [CFG_W-1:0] DEFAULT_CFG = 13'h0403
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [5:0]       cfg_addr,
  input  logic [CFG_W-1:0] cfg_wdata,
  output logic [CFG_W-1:0] cfg_rdata,
  input  logic             xfer,
  output logic             busy,
  output logic             done,
  output logic             serial_clock,
  output logic             serial_data_out,
  output logic             serial_load,
  input  logic             serial_data_in,
  output logic             chain_err
);

  localparam int TOTAL = NUM_IO * CFG_W;
  localparam int BW = $clog2(TOTAL);
  localparam int DW = $clog2(CLKDIV + 1);
  localparam int AW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [5:0] NUM_IO_A = 6'(NUM_IO);

  typedef enum logic [2:0] {
    IDLE, SHIFT_LO, SHIFT_HI, LOAD_SETUP, LOAD, DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CFG_W-1:0]    cfg_q [NUM_IO];
  logic [TOTAL-1:0]    img_q;
  logic [TOTAL-1:0]    flat;
  logic                accept;
  logic                addr_ok;
  logic                wr_en;
  logic [AW-1:0]       idx;
  logic                cur_bit;
  logic                div_last;

  assign addr_ok   = cfg_addr < NUM_IO_A;
  assign idx       = cfg_addr[AW-1:0];
  assign cfg_rdata = addr_ok ? cfg_q[idx] : '0;
  assign wr_en     = cfg_we && addr_ok && !busy;
  assign div_last  = (div_q == DIV_LAST);
  // Bit counter counts shifted bits; the image is sent from its top bit down,
  // which puts word NUM_IO-1 MSB first and word 0 bit 0 last.
  assign cur_bit   = img_q[LAST_BIT - bit_q];

  // Flatten the word array so word NUM_IO-1 occupies the top of the image
  always_comb begin
    flat = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      flat[i*CFG_W +: CFG_W] = cfg_q[i];
    end
  end

  // State, divider, bit counter and configuration word registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      for (int i = 0; i < NUM_IO; i++) begin
        cfg_q[i] <= DEFAULT_CFG;
      end
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      if (wr_en) begin
        cfg_q[idx] <= cfg_wdata;
      end
    end
  end

  // Snapshot of the words taken when a transfer is accepted
  always_ff @(posedge clock) begin
    if (accept) begin
      img_q <= flat;
    end
  end

  // Next-state and chain outputs; serial_clock period is 2*CLKDIV system clocks
  always_comb begin
    state_d         = state_q;
    div_d           = div_q;
    bit_d           = bit_q;
    accept          = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    serial_clock    = 1'b0;
    serial_data_out = 1'b0;
    serial_load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          accept  = 1'b1;
          state_d = SHIFT_LO;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      SHIFT_LO: begin
        busy            = 1'b1;
        serial_data_out = cur_bit;
        if (div_last) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        busy            = 1'b1;
        serial_clock    = 1'b1;
        serial_data_out = cur_bit;
        if (div_last) begin
          div_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = LOAD_SETUP;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LOAD_SETUP: begin
        busy = 1'b1;
        if (div_last) begin
          div_d   = '0;
          state_d = LOAD;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LOAD: begin
        busy        = 1'b1;
        serial_load = 1'b1;
        if (div_last) begin
          div_d   = '0;
          state_d = DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SERIAL_READBACK_EN
  logic [TOTAL-1:0] shadow_q;
  logic             err_q;
  logic             sclk_rise;

  // The edge leaving the last SHIFT_LO cycle is the one where serial_clock rises
  assign sclk_rise = (state_q == SHIFT_LO) && div_last;
  assign chain_err = err_q;

  // Returned bit k must match bit k of the image committed by the previous load
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q <= {NUM_IO{DEFAULT_CFG}};
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= 1'b0;
      end else if (sclk_rise && (serial_data_in != shadow_q[LAST_BIT - bit_q])) begin
        err_q <= 1'b1;
      end
      if (state_q == DONE) begin
        shadow_q <= img_q;
      end
    end
  end
`else
  logic unused_serial_data_in;

  assign unused_serial_data_in = serial_data_in;
  assign chain_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// tb/tb_gpio_cfg_loader.sv - self-checking bench for gpio_cfg_loader
module tb_gpio_cfg_loader;

  localparam int N = 38;
  localparam int W = 13;
  localparam int NB = 2;
  localparam logic [12:0] DEF = 13'h0403;

  typedef bit bitq_t[$];
  typedef struct {
    bit          we;
    logic [5:0]  addr;
    logic [12:0] wdata;
    logic [12:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_we, xfer, serial_data_in;
  logic [5:0]  cfg_addr;
  logic [12:0] cfg_wdata, cfg_rdata;
  logic        busy, done, serial_clock, serial_data_out, serial_load, chain_err;

  logic        b_cfg_we, b_xfer, b_sdi;
  logic [5:0]  b_cfg_addr;
  logic [12:0] b_cfg_wdata, b_cfg_rdata;
  logic        b_busy_o, b_done_o, b_sclk, b_sdo, b_sload, b_err;

  gpio_cfg_loader dut (
    .clock(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .xfer(xfer), .busy(busy),
    .done(done), .serial_clock(serial_clock), .serial_data_out(serial_data_out),
    .serial_load(serial_load), .serial_data_in(serial_data_in), .chain_err(chain_err)
  );

  gpio_cfg_loader #(.NUM_IO(NB), .CLKDIV(1)) dut_b (
    .clock(clk), .reset(reset), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr),
    .cfg_wdata(b_cfg_wdata), .cfg_rdata(b_cfg_rdata), .xfer(b_xfer), .busy(b_busy_o),
    .done(b_done_o), .serial_clock(b_sclk), .serial_data_out(b_sdo),
    .serial_load(b_sload), .serial_data_in(b_sdi), .chain_err(b_err)
  );

  int checks = 0;
  int failures = 0;
  logic [12:0] mw [N];
  logic [12:0] mwb [NB];
  bitq_t cap, bcap, chain, exp;
  int busy_cnt, load_cnt, done_cnt, done_bad;
  int b_busy, b_load, b_done, b_tog;
  bit sclk_prev = 0, busy_prev = 0, b_sclk_prev = 0;
  int flip_idx = -1;
  vec_t vecs [8];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected serial stream: highest word first, MSB first within a word
  function automatic bitq_t img_a();
    bitq_t q;
    for (int w = N - 1; w >= 0; w--)
      for (int b = W - 1; b >= 0; b--) q.push_back(mw[w][b]);
    return q;
  endfunction

  function automatic bitq_t img_b();
    bitq_t q;
    for (int w = NB - 1; w >= 0; w--)
      for (int b = W - 1; b >= 0; b--) q.push_back(mwb[w][b]);
    return q;
  endfunction

  // Monitor for the main instance, plus a chain of exactly N*W shift stages
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (serial_load) load_cnt++;
    if (done) begin
      done_cnt++;
      if (busy || !busy_prev) done_bad++;
    end
    if (serial_clock && !sclk_prev) begin
      cap.push_back(serial_data_out);
      void'(chain.pop_front());
      chain.push_back(serial_data_out);
    end
    serial_data_in = chain[0] ^ (cap.size() == flip_idx);
    sclk_prev = serial_clock;
    busy_prev = busy;
  end

  always @(negedge clk) begin
    if (b_busy_o) begin
      b_busy++;
      if (b_sclk != b_sclk_prev) b_tog++;
    end
    if (b_sload) b_load++;
    if (b_done_o) b_done++;
    if (b_sclk && !b_sclk_prev) bcap.push_back(b_sdo);
    b_sclk_prev = b_sclk;
  end

  task automatic wr(input int a, input logic [12:0] d);
    cfg_we = 1'b1; cfg_addr = 6'(a); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (a < N) mw[a] = d;
  endtask

  task automatic start();
    busy_cnt = 0; load_cnt = 0; done_cnt = 0; done_bad = 0;
    cap.delete();
    xfer = 1'b1;
    tick();
    xfer = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin
      tick();
      n++;
    end
    chk({nm, "_done_seen"}, int'(done_cnt != 0), 1);
    tick();
  endtask

  task automatic check_xfer(input string nm, input bitq_t e);
    int m = 0;
    for (int i = 0; i < e.size(); i++)
      if (i >= cap.size() || cap[i] != e[i]) m++;
    chk({nm, "_nbits"}, cap.size(), e.size());
    chk({nm, "_bit_mismatches"}, m, 0);
    chk({nm, "_busy_cycles"}, busy_cnt, 3960);
    chk({nm, "_load_cycles"}, load_cnt, 4);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_done_timing"}, done_bad, 0);
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; xfer = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    b_cfg_we = 1'b0; b_xfer = 1'b0; b_cfg_addr = '0; b_cfg_wdata = '0; b_sdi = 1'b0;
    serial_data_in = 1'b0;
    for (int i = 0; i < N; i++) mw[i] = DEF;
    for (int i = 0; i < NB; i++) mwb[i] = DEF;
    chain = img_a();

    vecs[0] = '{0, 6'd0,  13'h0000, 13'h0403};
    vecs[1] = '{0, 6'd37, 13'h0000, 13'h0403};
    vecs[2] = '{0, 6'd40, 13'h0000, 13'h0000};
    vecs[3] = '{1, 6'd37, 13'h1ABC, 13'h1ABC};
    vecs[4] = '{1, 6'd40, 13'h1FFF, 13'h0000};
    vecs[5] = '{1, 6'd0,  13'h0155, 13'h0155};
    vecs[6] = '{0, 6'd63, 13'h0000, 13'h0000};
    vecs[7] = '{0, 6'd36, 13'h0000, 13'h0403};

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sclk", serial_clock, 0);
    chk("rst_sdo", serial_data_out, 0);
    chk("rst_load", serial_load, 0);
    chk("rst_chain_err", chain_err, 0);
    reset = 1'b0;
    tick();

    // Register file table: write (if we) then read back the same address
    for (int i = 0; i < 8; i++) begin
      cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_wdata = vecs[i].wdata;
      tick();
      cfg_we = 1'b0;
      if (vecs[i].we && vecs[i].addr < N) mw[vecs[i].addr] = vecs[i].wdata;
      chk($sformatf("table_rdata_%0d", i), cfg_rdata, vecs[i].exp);
    end

    // First transfer: word 37 leads the stream
    exp = img_a();
    start();
    wait_done("x1");
    check_xfer("x1", exp);
    begin
      logic [12:0] f = '0;
      for (int i = 0; i < 13; i++) f = {f[11:0], cap[i]};
      chk("x1_first_word", f, 13'h1ABC);
    end

    // Write and xfer while busy must both be dropped
    exp = img_a();
    start();
    repeat (100) tick();
    cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 13'h0001; xfer = 1'b1;
    tick();
    cfg_we = 1'b0; xfer = 1'b0;
    wait_done("xb");
    check_xfer("xb", exp);
    repeat (5) tick();
    chk("xb_no_restart", busy, 0);
    cfg_addr = 6'd5;
    #1 chk("xb_word5_kept", cfg_rdata, mw[5]);
    exp = img_a();
    start();
    wait_done("xb2");
    check_xfer("xb2", exp);
    wr(5, 13'h0001);
    chk("post_done_word5", cfg_rdata, 13'h0001);

    // Randomized word sets against the stream model
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < N; w++) wr(w, 13'($urandom_range(0, 8191)));
      exp = img_a();
      start();
      wait_done($sformatf("rnd%0d", r));
      check_xfer($sformatf("rnd%0d", r), exp);
    end

    // Small instance: two words, one system clock per half period
    b_cfg_we = 1'b1;
    for (int w = 0; w < NB; w++) begin
      mwb[w] = 13'($urandom_range(0, 8191));
      b_cfg_addr = 6'(w); b_cfg_wdata = mwb[w];
      tick();
    end
    b_cfg_we = 1'b0;
    b_busy = 0; b_load = 0; b_done = 0; b_tog = 0; bcap.delete();
    exp = img_b();
    b_xfer = 1'b1;
    tick();
    b_xfer = 1'b0;
    for (int n = 0; n < 200 && b_done == 0; n++) tick();
    chk("b_done_pulses", b_done, 1);
    chk("b_busy_cycles", b_busy, 54);
    chk("b_sclk_toggles", b_tog, 52);
    chk("b_load_cycles", b_load, 1);
    begin
      int m = 0;
      for (int i = 0; i < exp.size(); i++)
        if (i >= bcap.size() || bcap[i] != exp[i]) m++;
      chk("b_bit_mismatches", m, 0);
      chk("b_nbits", bcap.size(), NB * W);
    end

    // Reset in the middle of a transfer aborts it without a done pulse
    start();
    repeat (999) tick();
    reset = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_sclk", serial_clock, 0);
    chk("abort_load", serial_load, 0);
    chk("abort_done", done, 0);
    reset = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", done_cnt, 0);
    for (int i = 0; i < N; i++) mw[i] = DEF;
    chain = img_a();
    cfg_addr = 6'd37;
    #1 chk("abort_word37", cfg_rdata, 13'h0403);
    cfg_addr = 6'd5;
    #1 chk("abort_word5", cfg_rdata, 13'h0403);

`ifdef SERIAL_READBACK_EN
    // Readback: clean, clean, one flipped return bit, then clear on next xfer
    for (int r = 0; r < 4; r++) begin
      flip_idx = (r == 2) ? 100 : -1;
      for (int w = 0; w < N; w++) wr(w, 13'($urandom_range(0, 8191)));
      exp = img_a();
      start();
      if (r == 3) chk("rb_cleared_on_accept", chain_err, 0);
      wait_done($sformatf("rb%0d", r));
      check_xfer($sformatf("rb%0d", r), exp);
      chk($sformatf("rb%0d_chain_err", r), chain_err, (r == 2) ? 1 : 0);
      if (r == 2) begin
        repeat (10) tick();
        chk("rb_err_sticky", chain_err, 1);
      end
    end
    flip_idx = -1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
